// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory-port arbiter
package mem_arb_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrobe;
        logic [1:0]  burst;
        logic [7:0]  len;
    } mem_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        ready;
        logic        last;
    } mem_resp_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;

    localparam int WDOG_W = 32;

    function automatic logic [WDOG_W-1:0] sat_inc(input logic [WDOG_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker: first valid index at or after ptr, wrapping
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest valid index is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid[wrap_add(ptr, i)]) begin
                found = 1'b1;
                idx   = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between NUM_REQ requesters
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][63:0]      req_addr,
    input  logic [NUM_REQ-1:0][63:0]      req_wdata,
    input  logic [NUM_REQ-1:0][7:0]       req_wstrobe,
    input  logic [NUM_REQ-1:0][1:0]       req_burst,
    input  logic [NUM_REQ-1:0][7:0]       req_len,
    output logic [NUM_REQ-1:0][63:0]      resp_rdata,
    output logic [NUM_REQ-1:0]            resp_ready,
    output logic [NUM_REQ-1:0]            resp_last,
    output logic [NUM_REQ-1:0]            resp_timeout,
    output logic                          mem_valid,
    output logic [63:0]                   mem_addr,
    output logic [63:0]                   mem_wdata,
    output logic [7:0]                    mem_wstrobe,
    output logic [1:0]                    mem_burst,
    output logic [7:0]                    mem_len,
    input  logic [63:0]                   mem_rdata,
    input  logic                          mem_ready,
    input  logic                          mem_last,
    output logic [NUM_REQ-1:0][31:0]      grant_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t                  state_q, state_d;
    logic [IW-1:0]               owner_q, owner_d;
    logic [IW-1:0]               rr_q, rr_d;
    logic [WDOG_W-1:0]           wdog_q, wdog_d;
    logic [NUM_REQ-1:0][31:0]    cnt_q, cnt_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] owner_nxt;
    logic          busy, tmo_hit, done_last, abort, force_rel;
    mem_req_t      cur_req;
    mem_resp_t     mresp;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .valid (req_valid),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        cur_req.valid   = req_valid[owner_q];
        cur_req.addr    = req_addr[owner_q];
        cur_req.wdata   = req_wdata[owner_q];
        cur_req.wstrobe = req_wstrobe[owner_q];
        cur_req.burst   = req_burst[owner_q];
        cur_req.len     = req_len[owner_q];
        mresp.rdata     = mem_rdata;
        mresp.ready     = mem_ready;
        mresp.last      = mem_last;

        busy      = (state_q == BUSY);
        tmo_hit   = (TIMEOUT != 0) && (wdog_q == WDOG_W'(TIMEOUT));
        // Completion outranks both abort and a coincident watchdog hit.
        done_last = busy && mresp.last;
        abort     = busy && !mresp.last && !cur_req.valid;
        force_rel = busy && !mresp.last && cur_req.valid && tmo_hit;
        owner_nxt = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

        mem_valid   = busy && cur_req.valid;
        mem_addr    = cur_req.addr;
        mem_wdata   = cur_req.wdata;
        mem_wstrobe = cur_req.wstrobe;
        mem_burst   = cur_req.burst;
        mem_len     = cur_req.len;

        resp_rdata   = {NUM_REQ{mresp.rdata}};
        resp_ready   = '0;
        resp_last    = '0;
        resp_timeout = '0;
        if (busy) begin
            resp_ready[owner_q]   = mresp.ready;
            resp_last[owner_q]    = mresp.last;
            resp_timeout[owner_q] = force_rel;
        end
        grant_count = cnt_q;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        wdog_d  = wdog_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    wdog_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wdog_d = sat_inc(wdog_q);
                if (done_last || abort || force_rel) begin
                    state_d = DRAIN;
                    rr_d    = owner_nxt;
                end
                if (done_last) cnt_d[owner_q] = cnt_q[owner_q] + 32'd1;
            end
            // One dead cycle with mem_valid low lets the memory reset its delay counter.
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            wdog_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            wdog_q  <= wdog_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int NR  = 2;
    localparam int TMO = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0][63:0]  req_addr;
    logic [NR-1:0][63:0]  req_wdata;
    logic [NR-1:0][7:0]   req_wstrobe;
    logic [NR-1:0][1:0]   req_burst;
    logic [NR-1:0][7:0]   req_len;
    logic [NR-1:0][63:0]  resp_rdata;
    logic [NR-1:0]        resp_ready, resp_last, resp_timeout;
    logic                 mem_valid;
    logic [63:0]          mem_addr, mem_wdata, mem_rdata;
    logic [7:0]           mem_wstrobe, mem_len;
    logic [1:0]           mem_burst;
    logic                 mem_ready, mem_last;
    logic [NR-1:0][31:0]  grant_count;

    mem_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrobe(req_wstrobe), .req_burst(req_burst), .req_len(req_len),
        .resp_rdata(resp_rdata), .resp_ready(resp_ready), .resp_last(resp_last),
        .resp_timeout(resp_timeout),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrobe(mem_wstrobe), .mem_burst(mem_burst), .mem_len(mem_len),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_last(mem_last),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   lat    = 0;
    logic stall  = 1'b0;

    // Memory model: 64 words, ready after 'lat' wait cycles per beat, INCR beats.
    logic [63:0] mem [64];
    int          wait_cnt;
    logic [7:0]  beat;
    logic [5:0]  midx;

    function automatic logic [63:0] pat(input int i);
        return 64'h5A5A_0000_0000_0000 | 64'(i);
    endfunction

    assign midx      = mem_addr[8:3] + beat[5:0];
    assign mem_ready = mem_valid && !stall && (wait_cnt >= lat);
    assign mem_last  = mem_ready && (beat == mem_len);
    assign mem_rdata = mem[midx];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
            wait_cnt <= 0;
            beat     <= '0;
        end else if (!mem_valid) begin
            wait_cnt <= 0;
            beat     <= '0;
        end else if (mem_ready) begin
            for (int b = 0; b < 8; b++)
                if (mem_wstrobe[b]) mem[midx][8*b +: 8] <= mem_wdata[8*b +: 8];
            wait_cnt <= 0;
            beat     <= mem_last ? 8'd0 : beat + 8'd1;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_last(input logic idx, output int beats, output logic [63:0] rd,
                             output logic tmo);
        logic done;
        beats = 0;
        rd    = '0;
        tmo   = 1'b0;
        done  = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            #3;
            if (resp_ready[idx]) begin
                beats++;
                rd = resp_rdata[idx];
            end
            if (|resp_timeout) tmo = 1'b1;
            if (resp_last[idx]) done = 1'b1;
            cyc();
        end
        req_valid[idx] = 1'b0;
        chk("last_seen", 64'(done), 64'd1);
    endtask

    task automatic txn(input logic idx, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] ws, input logic [7:0] ln, input logic [1:0] bt,
                       output int beats, output logic [63:0] rd, output logic tmo);
        cyc();
        assert (!req_valid[idx]) else $error("request fields changed while requester active");
        req_addr[idx]    = a;
        req_wdata[idx]   = wd;
        req_wstrobe[idx] = ws;
        req_len[idx]     = ln;
        req_burst[idx]   = bt;
        req_valid[idx]   = 1'b1;
        wait_last(idx, beats, rd, tmo);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int          beats, npulse, tk;
        logic [63:0] rd;
        logic        tmo, drop0, drop1, seen1;
        logic [1:0]  e, tv;

        reset = 1'b1;
        req_valid = '0; req_addr = '0; req_wdata = '0;
        req_wstrobe = '0; req_burst = '0; req_len = '0;
        repeat (2) cyc();
        #3;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd0);
        chk("rst_resp_last", 64'(resp_last), 64'd0);
        chk("rst_resp_timeout", 64'(resp_timeout), 64'd0);
        chk("rst_count0", 64'(grant_count[0]), 64'd0);
        chk("rst_count1", 64'(grant_count[1]), 64'd0);
        cyc(); reset = 1'b0;

        // single read: registered grant, ready/last together
        cyc();
        req_addr[0] = 64'h100; req_len[0] = 8'd0; req_burst[0] = BURST_FIXED; req_valid[0] = 1'b1;
        #3; chk("t1_no_same_cycle_valid", 64'(mem_valid), 64'd0);
        cyc(); #3;
        chk("t1_mem_valid", 64'(mem_valid), 64'd1);
        chk("t1_mem_addr", mem_addr, 64'h100);
        chk("t1_ready", 64'(resp_ready), 64'b01);
        chk("t1_last", 64'(resp_last), 64'b01);
        chk("t1_rdata", resp_rdata[0], pat(32));
        cyc(); req_valid[0] = 1'b0; #3;
        chk("t1_drain_valid", 64'(mem_valid), 64'd0);
        chk("t1_count0", 64'(grant_count[0]), 64'd1);

        // contention from reset: grants every 3 cycles, alternating 0,1,0,1
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0;
        cyc();
        req_addr[0] = 64'h10; req_addr[1] = 64'h18; req_len = '0; req_valid = 2'b11;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (k == 11) req_valid = 2'b00;
            #3;
            e = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t2_ready_c%0d", k), 64'(resp_ready), 64'(e));
            if (k % 3 == 0)
                chk($sformatf("t2_addr_c%0d", k), mem_addr, ((k / 3) % 2 == 0) ? 64'h10 : 64'h18);
        end
        chk("t2_count0", 64'(grant_count[0]), 64'd2);
        chk("t2_count1", 64'(grant_count[1]), 64'd2);

        // write by req1, read-back by req0
        txn(1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D, 8'hFF, 8'd0, BURST_INCR, beats, rd, tmo);
        chk("t3_wr_beats", 64'(beats), 64'd1);
        txn(1'b0, 64'h40, 64'd0, 8'h00, 8'd0, BURST_INCR, beats, rd, tmo);
        chk("t3_readback", rd, 64'hDEADBEEF_CAFEF00D);
        chk("t3_count0", 64'(grant_count[0]), 64'd3);
        chk("t3_count1", 64'(grant_count[1]), 64'd3);

        // 4-beat INCR burst
        txn(1'b0, 64'h100, 64'd0, 8'h00, 8'd3, BURST_INCR, beats, rd, tmo);
        chk("t4_beats", 64'(beats), 64'd4);
        chk("t4_last_rdata", rd, pat(35));
        chk("t4_count0", 64'(grant_count[0]), 64'd4);

        // last coincides with watchdog == TIMEOUT: completion, no pulse
        lat = TMO;
        txn(1'b1, 64'h18, 64'd0, 8'h00, 8'd0, BURST_FIXED, beats, rd, tmo);
        chk("t5_beats", 64'(beats), 64'd1);
        chk("t5_no_timeout", 64'(tmo), 64'd0);
        chk("t5_rdata", rd, pat(3));
        chk("t5_count1", 64'(grant_count[1]), 64'd4);

        // abort: req0 drops valid one cycle after grant, pending req1 served after DRAIN
        lat = 5;
        cyc();
        req_addr[0] = 64'h20; req_len[0] = 8'd0; req_wstrobe[0] = 8'h00; req_valid[0] = 1'b1;
        cyc();
        req_addr[1] = 64'h28; req_len[1] = 8'd0; req_wstrobe[1] = 8'h00; req_valid[1] = 1'b1;
        #3;
        chk("t6_grant0_valid", 64'(mem_valid), 64'd1);
        chk("t6_grant0_addr", mem_addr, 64'h20);
        cyc(); req_valid[0] = 1'b0; #3;
        chk("t6_abort_valid", 64'(mem_valid), 64'd0);
        chk("t6_abort_ready", 64'(resp_ready), 64'd0);
        cyc(); #3;
        chk("t6_drain_valid", 64'(mem_valid), 64'd0);
        chk("t6_count0_kept", 64'(grant_count[0]), 64'd4);
        cyc(); #3;
        chk("t6_idle_valid", 64'(mem_valid), 64'd0);
        cyc(); #3;
        chk("t6_grant1_valid", 64'(mem_valid), 64'd1);
        chk("t6_grant1_addr", mem_addr, 64'h28);
        cyc();
        wait_last(1'b1, beats, rd, tmo);
        chk("t6_count1", 64'(grant_count[1]), 64'd5);
        lat = 0;

        // timeout: memory stalls, pulse on the 8th BUSY cycle after grant, then req1 served
        stall = 1'b1;
        cyc();
        req_addr[0] = 64'h30; req_len[0] = 8'd0; req_valid[0] = 1'b1;
        cyc();
        req_addr[1] = 64'h38; req_len[1] = 8'd0; req_valid[1] = 1'b1;
        #3;
        chk("t7_grant_addr", mem_addr, 64'h30);
        npulse = 0; tk = -1; tv = '0; drop0 = 1'b0; drop1 = 1'b0; seen1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (drop0) begin req_valid[0] = 1'b0; stall = 1'b0; drop0 = 1'b0; end
            if (drop1) begin req_valid[1] = 1'b0; drop1 = 1'b0; end
            #3;
            if (|resp_timeout) begin npulse++; tk = k; tv = resp_timeout; drop0 = 1'b1; end
            if (resp_last[1]) begin seen1 = 1'b1; drop1 = 1'b1; end
        end
        chk("t7_pulse_count", 64'(npulse), 64'd1);
        chk("t7_pulse_cycle", 64'(tk), 64'(TMO));
        chk("t7_pulse_owner", 64'(tv), 64'b01);
        chk("t7_req1_served", 64'(seen1), 64'd1);
        chk("t7_count0", 64'(grant_count[0]), 64'd4);
        chk("t7_count1", 64'(grant_count[1]), 64'd6);

        // leave rr pointer at 1, then reset in the middle of a burst
        txn(1'b0, 64'h100, 64'd0, 8'h00, 8'd0, BURST_FIXED, beats, rd, tmo);
        lat = 2;
        cyc();
        req_addr[0] = 64'h100; req_len[0] = 8'd3; req_burst[0] = BURST_INCR; req_valid[0] = 1'b1;
        cyc(); #3;
        chk("t8_busy", 64'(mem_valid), 64'd1);
        cyc(); reset = 1'b1;
        cyc(); #3;
        chk("t8_rst_valid", 64'(mem_valid), 64'd0);
        chk("t8_rst_ready", 64'(resp_ready), 64'd0);
        chk("t8_rst_last", 64'(resp_last), 64'd0);
        chk("t8_rst_count0", 64'(grant_count[0]), 64'd0);
        chk("t8_rst_count1", 64'(grant_count[1]), 64'd0);
        cyc(); reset = 1'b0;
        req_addr[0] = 64'h10; req_len[0] = 8'd0; req_addr[1] = 64'h18; req_len[1] = 8'd0;
        req_valid = 2'b11;
        #3;
        chk("t8_idle", 64'(mem_valid), 64'd0);
        cyc(); #3;
        chk("t8_rr_reset_owner", mem_addr, 64'h10);
        cyc();
        wait_last(1'b0, beats, rd, tmo);
        wait_last(1'b1, beats, rd, tmo);
        chk("t8_count0", 64'(grant_count[0]), 64'd1);
        chk("t8_count1", 64'(grant_count[1]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
